// File: rtl/booth4_seq_encoder.sv
// Sequential radix-4 Booth recoder.
// It captures a multiplier operand and emits one Booth triplet per accepted
// handshake. Each triplet is accompanied by a decoded negate/double/zero
// control for the downstream partial-product generator.
module booth4_seq_encoder #(
    parameter int WIDTH = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] B,
    input  logic             code_ready,
    output logic             code_valid,
    output logic [2:0]       code,
    output logic             pp_neg,
    output logic             pp_two,
    output logic             pp_zero,
    output logic [3:0]       code_idx,
    output logic             code_last,
    output logic             busy,
    output logic             done
);

    // Shift window: two extension bits, the operand, and the implicit b[-1].
    localparam int SW = WIDTH + 3;
    localparam logic [3:0] LAST_SIGNED   = 4'(WIDTH / 2 - 1);
    localparam logic [3:0] LAST_UNSIGNED = 4'(WIDTH / 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sh_q, sh_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    last_idx_q, last_idx_d;
    logic          valid_s;
    logic [2:0]    code_s;
    logic [2:0]    dec_s;

    // Booth triplet decode: returns {neg, two, zero}.
    function automatic logic [2:0] booth_decode(input logic [2:0] c);
        logic neg_f;
        logic two_f;
        logic zero_f;
        neg_f  = c[2] & (c != 3'b111);
        two_f  = (c == 3'b011) | (c == 3'b100);
        zero_f = (c == 3'b000) | (c == 3'b111);
        return {neg_f, two_f, zero_f};
    endfunction

    // State, operand window and index registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            idx_q      <= 4'd0;
            last_idx_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
        end
    end

    // Next-state logic: capture in IDLE, shift per handshake in EMIT.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Signed operands sign-extend, unsigned ones zero-extend;
                    // the extra triplet in unsigned mode then sees {0,0,msb}.
                    if (signed_mode) begin
                        sh_d       = {{2{B[WIDTH-1]}}, B, 1'b0};
                        last_idx_d = LAST_SIGNED;
                    end else begin
                        sh_d       = {2'b00, B, 1'b0};
                        last_idx_d = LAST_UNSIGNED;
                    end
                    idx_d   = 4'd0;
                    state_d = ST_EMIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (code_ready) begin
                    if (idx_q == last_idx_q) begin
                        // Clear the window so idle outputs read as zero.
                        sh_d    = '0;
                        idx_d   = 4'd0;
                        state_d = ST_DONE;
                    end else begin
                        sh_d  = {2'b00, sh_q[SW-1:2]};
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                sh_d       = '0;
                idx_d      = 4'd0;
                last_idx_d = 4'd0;
            end
        endcase
    end

    // Output decode from registered state; everything is zero outside EMIT.
    always_comb begin
        valid_s = (state_q == ST_EMIT);
        if (valid_s) begin
            code_s = sh_q[2:0];
            dec_s  = booth_decode(sh_q[2:0]);
        end else begin
            code_s = 3'b000;
            dec_s  = 3'b000;
        end
    end

    assign code_valid = valid_s;
    assign code       = code_s;
    assign pp_neg     = dec_s[2];
    assign pp_two     = dec_s[1];
    assign pp_zero    = dec_s[0];
    assign code_idx   = valid_s ? idx_q : 4'd0;
    assign code_last  = valid_s & (idx_q == last_idx_q);
    assign busy       = valid_s;
    assign done       = (state_q == ST_DONE);

endmodule

// File: doc/booth4_seq_encoder.md
BOOTH4_SEQ_ENCODER -- requirements
Module: booth4_seq_encoder

Interface
REQ-001 Parameter: WIDTH, 16, multiplier operand width in bits; even, at least 4.
REQ-002 Port: sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  load request; sampled only in IDLE.
REQ-005 Port: signed_mode  input  1  1 means B is two's complement, 0 means B is unsigned; captured with start.
REQ-006 Port: B  input  WIDTH  multiplier operand; captured with start.
REQ-007 Port: code_ready  input  1  downstream partial-product decoder accepts the current code.
REQ-008 Port: code_valid  output  1  code outputs hold a valid Booth radix-4 triplet.
REQ-009 Port: code  output  3  triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
REQ-010 Port: pp_neg  output  1  the partial product is negated (code[2]=1 and code is not 3'b111).
REQ-011 Port: pp_two  output  1  magnitude 2A (code 3'b011 or 3'b100).
REQ-012 Port: pp_zero  output  1  magnitude 0 (code 3'b000 or 3'b111).
REQ-013 Port: code_idx  output  4  partial-product index i, starting at 0.
REQ-014 Port: code_last  output  1  the current code is the final one for this operand.
REQ-015 Port: busy  output  1  high from start acceptance until the final handshake.
REQ-016 Port: done  output  1  one-cycle pulse in the cycle after the final handshake.

Function
REQ-017 The FSM SHALL have the states IDLE, EMIT and DONE, encoded in registers.
REQ-018 In IDLE with start=1, the block SHALL capture B and signed_mode, set idx=0 and enter EMIT on the next edge; busy and code_valid rise in that same cycle.
REQ-019 Latency from start to the first code_valid SHALL be exactly 1 cycle.
REQ-020 The code count N SHALL be WIDTH/2 when signed_mode=1 and WIDTH/2+1 when signed_mode=0.
REQ-021 For unsigned mode, B SHALL be zero-extended by 2 bits, so the final triplet is {0,0,B[WIDTH-1]}.
REQ-022 In EMIT, code_valid SHALL be 1, and all code outputs SHALL remain stable while code_ready=0.
REQ-023 A handshake (code_valid and code_ready) SHALL advance idx by 1 on the next edge with no bubble, so there is 1 code per cycle when code_ready is held high.
REQ-024 code_last SHALL be 1 exactly when idx=N-1.
REQ-025 A handshake with code_last=1 SHALL move the FSM to DONE; in DONE, done=1, busy=0, code_valid=0, and the FSM returns to IDLE on the next edge.
REQ-026 start SHALL be ignored in EMIT and DONE; no re-capture and no queuing.
REQ-027 When code_valid=0, the outputs code, pp_neg, pp_two, pp_zero, code_idx and code_last SHALL be 0.
REQ-028 pp_neg, pp_two and pp_zero SHALL be combinational decodes of the registered code and SHALL be consistent with REQ-010 to REQ-012 in every cycle.
REQ-029 The sum of digit(i)*4^i over all emitted codes SHALL equal B: signed when signed_mode=1, unsigned when signed_mode=0.

Reset
REQ-030 While sys_rst_n=0, the FSM SHALL be IDLE and every output SHALL be 0, independent of sys_clk.
REQ-031 Reset asserted mid-EMIT SHALL abort the operand immediately, with no done pulse; after release, the block is in IDLE and accepts start on the first edge.

Verification
REQ-032 Signed: B=16'h5C0B, signed_mode=1, code_ready=1 -> 8 codes 110,101,001,000,000,110,011,010 (digits -1,-1,+1,0,0,-1,+2,+1), code_last on idx 7, done 1 cycle later.
REQ-033 Unsigned: B=16'hFFFF, signed_mode=0 -> 9 codes: 110, seven times 111, then 001; digit sum equals 65535.
REQ-034 Signed: B=16'hFFFF -> 8 codes: 110 then seven times 111, equal to -1; pp_zero=1 on idx 1 to 7.
REQ-035 Backpressure: code_ready=0 for 3 cycles at idx 2 -> code and code_idx held for 3 cycles, then continue; start pulsed during EMIT is ignored.
REQ-036 Reset: sys_rst_n low at idx 4 between clock edges -> outputs go to 0 immediately, no done pulse; a new start after release emits from idx 0.
REQ-037 Random: 10,000 random B values in both modes with random code_ready -> REQ-029 identity holds and pp_neg/pp_two/pp_zero are consistent every cycle.
